// File: rtl/sdram_march_tester.sv
// SDRAM march self-test: writes a selectable pattern over an inclusive address range,
// reads it back, and reports pass/fail, a saturating error count and the first miscompare.
module sdram_march_tester #(
   parameter int unsigned       ADDR_W    = 25,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ERR_W     = 16,
   parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003),
   parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              START,
   input  logic [1:0]        MODE,
   input  logic              STOP_ON_FAIL,
   input  logic [ADDR_W-1:0] ADDR_LO,
   input  logic [ADDR_W-1:0] ADDR_HI,
   input  logic              INIT_DONE,
   input  logic              RW_ACK,
   input  logic [DATA_W-1:0] DATA_READ,
   output logic [ADDR_W-1:0] DATA_ADDR,
   output logic [DATA_W-1:0] DATA_WRITE,
   output logic              RW_WRITE,
   output logic              RW_READ,
   output logic              BUSY,
   output logic              PASS,
   output logic              FAIL,
   output logic [ERR_W-1:0]  ERR_COUNT,
   output logic [ADDR_W-1:0] FAIL_ADDR,
   output logic [DATA_W-1:0] FAIL_DATA
);

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_IDLE,
      S_WRITE,
      S_WR_GAP,
      S_READ,
      S_CHECK,
      S_RD_GAP,
      S_DONE
   } state_t;

   localparam logic [DATA_W-1:0] CHK_5 = DATA_W'({DATA_W{2'b01}});

   function automatic logic [DATA_W-1:0] lfsr_adv(input logic [DATA_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] s);
      case (m)
         2'd0:    return DATA_W'(a);
         2'd1:    return ~DATA_W'(a);
         2'd2:    return s;
         default: return a[0] ? ~CHK_5 : CHK_5;
      endcase
   endfunction

   state_t              state_q;
   logic [1:0]          mode_q;
   logic                sof_q;
   logic [ADDR_W-1:0]   lo_q, hi_q, addr_q;
   logic [DATA_W-1:0]   lfsr_q, rdata_q;
   logic [ERR_W-1:0]    err_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [DATA_W-1:0]   fail_data_q;
   logic                pass_q, fail_q, busy_q, wr_q, rd_q;
   logic [ADDR_W-1:0]   daddr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [ADDR_W-1:0]   addr_inc;
   logic [DATA_W-1:0]   lfsr_next, exp_word, next_word, first_word;
   logic                mismatch, any_err;

   assign addr_inc   = addr_q + ADDR_W'(1);
   assign lfsr_next  = lfsr_adv(lfsr_q);
   assign exp_word   = pattern(mode_q, addr_q, lfsr_q);
   assign next_word  = pattern(mode_q, addr_inc, lfsr_next);
   assign first_word = pattern(MODE, ADDR_LO, LFSR_SEED);
   assign mismatch   = (rdata_q != exp_word);
   // err_q saturates and never returns to zero within a run, so this is the post-CHECK status.
   assign any_err    = mismatch || (err_q != '0);

   // NOTE: state is updated with non-blocking assignments only, and the async reset clears
   // every register so strobes and status drop the instant Reset rises.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_INIT_WAIT;
         mode_q      <= '0;
         sof_q       <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
         addr_q      <= '0;
         lfsr_q      <= '0;
         rdata_q     <= '0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         busy_q      <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         daddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            S_INIT_WAIT: begin
               if (INIT_DONE) state_q <= S_IDLE;
            end
            S_IDLE, S_DONE: begin
               if (START) begin
                  mode_q      <= MODE;
                  sof_q       <= STOP_ON_FAIL;
                  lo_q        <= ADDR_LO;
                  hi_q        <= ADDR_HI;
                  addr_q      <= ADDR_LO;
                  lfsr_q      <= LFSR_SEED;
                  err_q       <= '0;
                  fail_addr_q <= '0;
                  fail_data_q <= '0;
                  fail_q      <= 1'b0;
                  if (ADDR_LO > ADDR_HI) begin
                     pass_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     pass_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     wr_q    <= 1'b1;
                     daddr_q <= ADDR_LO;
                     wdata_q <= first_word;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (RW_ACK) begin
                  wr_q    <= 1'b0;
                  daddr_q <= '0;
                  wdata_q <= '0;
                  if (addr_q == hi_q) begin
                     addr_q  <= lo_q;
                     lfsr_q  <= LFSR_SEED;
                     state_q <= S_RD_GAP;
                  end else begin
                     state_q <= S_WR_GAP;
                  end
               end
            end
            S_WR_GAP: begin
               addr_q  <= addr_inc;
               lfsr_q  <= lfsr_next;
               wr_q    <= 1'b1;
               daddr_q <= addr_inc;
               wdata_q <= next_word;
               state_q <= S_WRITE;
            end
            S_RD_GAP: begin
               rd_q    <= 1'b1;
               daddr_q <= addr_q;
               state_q <= S_READ;
            end
            S_READ: begin
               if (RW_ACK) begin
                  rdata_q <= DATA_READ;
                  rd_q    <= 1'b0;
                  daddr_q <= '0;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (err_q != '1) err_q <= err_q + ERR_W'(1);
                  if (err_q == '0) begin
                     fail_addr_q <= addr_q;
                     fail_data_q <= rdata_q;
                  end
               end
               if ((mismatch && sof_q) || (addr_q == hi_q)) begin
                  busy_q  <= 1'b0;
                  pass_q  <= !any_err;
                  fail_q  <= any_err;
                  state_q <= S_DONE;
               end else begin
                  addr_q  <= addr_inc;
                  lfsr_q  <= lfsr_next;
                  state_q <= S_RD_GAP;
               end
            end
            default: state_q <= S_INIT_WAIT;
         endcase
      end
   end

   assign DATA_ADDR  = daddr_q;
   assign DATA_WRITE = wdata_q;
   assign RW_WRITE   = wr_q;
   assign RW_READ    = rd_q;
   assign BUSY       = busy_q;
   assign PASS       = pass_q;
   assign FAIL       = fail_q;
   assign ERR_COUNT  = err_q;
   assign FAIL_ADDR  = fail_addr_q;
   assign FAIL_DATA  = fail_data_q;

endmodule

// File: tb/tb_sdram_march_tester.sv
// Bench for sdram_march_tester: a 2-cycle-latency controller model with read corruption,
// and a scoreboard of expected transfers consumed as the controller acknowledges them.
module tb_sdram_march_tester;

   localparam int AW = 25;
   localparam int DW = 32;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } xfer_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = '0;
   logic          stop_on_fail = 1'b0;
   logic [AW-1:0] addr_lo = '0, addr_hi = '0;
   logic          init_done = 1'b0;
   logic          rw_ack = 1'b0;
   logic [DW-1:0] data_read = '0;

   logic [AW-1:0] data_addr, fail_addr, s_data_addr, s_fail_addr;
   logic [DW-1:0] data_write, fail_data, s_data_write, s_fail_data;
   logic          rw_write, rw_read, busy, pass, fail;
   logic          s_rw_write, s_rw_read, s_busy, s_pass, s_fail;
   logic [15:0]   err_count;
   logic [1:0]    s_err_count;

   int            n_vec = 0;
   int            n_miss = 0;

   xfer_t         sb_q[$];
   xfer_t         exp_x;
   logic [DW-1:0] mem [logic [AW-1:0]];
   bit            corrupt_set [logic [AW-1:0]];

   always #5 clk = ~clk;

   sdram_march_tester u_dut (
      .Clk(clk), .Reset(rst), .START(start), .MODE(mode), .STOP_ON_FAIL(stop_on_fail),
      .ADDR_LO(addr_lo), .ADDR_HI(addr_hi), .INIT_DONE(init_done), .RW_ACK(rw_ack),
      .DATA_READ(data_read), .DATA_ADDR(data_addr), .DATA_WRITE(data_write),
      .RW_WRITE(rw_write), .RW_READ(rw_read), .BUSY(busy), .PASS(pass), .FAIL(fail),
      .ERR_COUNT(err_count), .FAIL_ADDR(fail_addr), .FAIL_DATA(fail_data)
   );

   // Narrow-counter twin sharing all stimulus, used only for the saturation behaviour.
   sdram_march_tester #(.ERR_W(2)) u_dut_sat (
      .Clk(clk), .Reset(rst), .START(start), .MODE(mode), .STOP_ON_FAIL(stop_on_fail),
      .ADDR_LO(addr_lo), .ADDR_HI(addr_hi), .INIT_DONE(init_done), .RW_ACK(rw_ack),
      .DATA_READ(data_read), .DATA_ADDR(s_data_addr), .DATA_WRITE(s_data_write),
      .RW_WRITE(s_rw_write), .RW_READ(s_rw_read), .BUSY(s_busy), .PASS(s_pass), .FAIL(s_fail),
      .ERR_COUNT(s_err_count), .FAIL_ADDR(s_fail_addr), .FAIL_DATA(s_fail_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_pat(input logic [1:0] m, input logic [AW-1:0] a,
                                             input int idx);
      logic [DW-1:0] s;
      s = 32'h1;
      case (m)
         2'd0: return {7'd0, a};
         2'd1: return ~{7'd0, a};
         2'd2: begin
            for (int k = 0; k < idx; k++)
               s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
            return s;
         end
         default: return a[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      endcase
   endfunction

   // Controller model and bus monitor, sampled on the falling edge.
   int  wait_cnt = 0, gap_cnt = 0;
   bit  have_prev = 0, prev_strobe = 0, prev_wr = 0, strobe;

   always @(negedge clk) begin
      if (rst) begin
         rw_ack = 1'b0; wait_cnt = 0; gap_cnt = 0; have_prev = 0; prev_strobe = 0;
      end else begin
         strobe = rw_write | rw_read;
         check("both_strobes", 64'(rw_write & rw_read), 64'(0));
         if (!strobe) check("idle_bus", {7'd0, data_addr, data_write}, 64'(0));
         if (!busy) have_prev = 0;
         else if (strobe && !prev_strobe) begin
            if (have_prev) check("gap", 64'(gap_cnt), (rw_read && !prev_wr) ? 64'(2) : 64'(1));
            have_prev = 1;
         end
         if (strobe) begin
            gap_cnt = 0;
            prev_wr = rw_write;
         end else begin
            gap_cnt++;
         end
         prev_strobe = strobe;

         if (rw_ack) begin
            rw_ack = 1'b0;
         end else if (strobe) begin
            wait_cnt++;
            if (wait_cnt == 2) begin
               wait_cnt = 0;
               rw_ack = 1'b1;
               check("xfer_expected", 64'(sb_q.size() != 0), 64'(1));
               if (sb_q.size() != 0) begin
                  exp_x = sb_q.pop_front();
                  check("xfer_dir", 64'(rw_write), 64'(exp_x.wr));
                  check("xfer_addr", 64'(data_addr), 64'(exp_x.addr));
                  if (exp_x.wr) check("xfer_wdata", 64'(data_write), 64'(exp_x.data));
               end
               if (rw_write) mem[data_addr] = data_write;
               else data_read = (mem.exists(data_addr) ? mem[data_addr] : '0) ^
                                (corrupt_set.exists(data_addr) ? 32'd1 : 32'd0);
            end
         end
      end
   end

   task automatic load_sb(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                          input logic [1:0] m, input bit sof, output int errs,
                          output logic [AW-1:0] f_addr, output logic [DW-1:0] f_data);
      errs = 0; f_addr = '0; f_data = '0;
      if (lo > hi) return;
      for (longint a = lo; a <= hi; a++)
         sb_q.push_back('{1'b1, AW'(a), exp_pat(m, AW'(a), int'(a - lo))});
      for (longint a = lo; a <= hi; a++) begin
         sb_q.push_back('{1'b0, AW'(a), '0});
         if (corrupt_set.exists(AW'(a))) begin
            errs++;
            if (errs == 1) begin
               f_addr = AW'(a);
               f_data = exp_pat(m, AW'(a), int'(a - lo)) ^ 32'd1;
            end
            if (sof) break;
         end
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                              input logic [1:0] m, input bit sof);
      @(negedge clk);
      addr_lo = lo; addr_hi = hi; mode = m; stop_on_fail = sof; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_test(input string name, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                           input logic [1:0] m, input bit sof, input bit mid_start);
      int errs, cyc;
      logic [AW-1:0] f_addr;
      logic [DW-1:0] f_data;
      load_sb(lo, hi, m, sof, errs, f_addr, f_data);
      pulse_start(lo, hi, m, sof);
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (mid_start && cyc == 20) begin
            start = 1'b1; mode = ~m; addr_lo = lo + 1'b1;
         end else if (cyc == 21) begin
            start = 1'b0; mode = m; addr_lo = lo;
         end
      end
      check({name, ":done_in_time"}, 64'(cyc < 3000), 64'(1));
      check({name, ":pass"}, 64'(pass), 64'(errs == 0));
      check({name, ":fail"}, 64'(fail), 64'(errs != 0));
      check({name, ":busy"}, 64'(busy), 64'(0));
      check({name, ":err_count"}, 64'(err_count), 64'(errs));
      check({name, ":err_sat"}, 64'(s_err_count), 64'(errs > 3 ? 3 : errs));
      check({name, ":fail_addr"}, 64'(fail_addr), 64'(f_addr));
      check({name, ":fail_data"}, 64'(fail_data), 64'(f_data));
      check({name, ":sb_left"}, 64'(sb_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      repeat (2) @(negedge clk);
      check("reset:strobes_bus",
            {2'd0, data_addr, data_write, rw_write, rw_read, busy, pass, fail}, 64'(0));
      check("reset:err_info", {err_count, fail_addr, 23'd0}, 64'(0));
      check("reset:fail_data", 64'(fail_data), 64'(0));
      rst = 1'b0;
      init_done = 1'b1;
      repeat (2) @(negedge clk);

      run_test("mode0", 25'd0, 25'd15, 2'd0, 1'b0, 1'b1);

      corrupt_set[25'd5] = 1'b1;
      corrupt_set[25'd9] = 1'b1;
      run_test("mode1_corrupt", 25'd0, 25'd15, 2'd1, 1'b0, 1'b0);
      run_test("mode1_stop", 25'd0, 25'd15, 2'd1, 1'b1, 1'b0);
      corrupt_set.delete();

      run_test("mode2_lfsr", 25'd100, 25'd103, 2'd2, 1'b0, 1'b0);
      run_test("mode3_chk", 25'd6, 25'd9, 2'd3, 1'b0, 1'b0);
      run_test("top_addr", 25'h1FF_FFFF, 25'h1FF_FFFF, 2'd0, 1'b0, 1'b0);
      run_test("empty_range", 25'd8, 25'd4, 2'd0, 1'b0, 1'b0);

      foreach (corrupt_set[k]) corrupt_set.delete(k);
      for (int k = 1; k <= 9; k += 2) corrupt_set[AW'(k)] = 1'b1;
      run_test("saturate", 25'd0, 25'd15, 2'd0, 1'b0, 1'b0);
      corrupt_set.delete();

      // Abort mid-write with an asynchronous reset, then confirm START waits for INIT_DONE.
      begin
         int errs;
         logic [AW-1:0] f_addr;
         logic [DW-1:0] f_data;
         load_sb(25'd0, 25'd15, 2'd0, 1'b0, errs, f_addr, f_data);
         pulse_start(25'd0, 25'd15, 2'd0, 1'b0);
         repeat (15) @(negedge clk);
         cyc = 0;
         while (!rw_write && cyc < 50) begin
            @(negedge clk);
            cyc++;
         end
         check("rst_mid:write_seen", 64'(rw_write), 64'(1));
         #2;
         rst = 1'b1;
         init_done = 1'b0;
         sb_q.delete();
         #1;
         check("rst_mid:outputs",
               {2'd0, data_addr, data_write, rw_write, rw_read, busy, pass, fail}, 64'(0));
         check("rst_mid:err_count", 64'(err_count), 64'(0));
         @(negedge clk);
         rst = 1'b0;
         pulse_start(25'd0, 25'd3, 2'd0, 1'b0);
         repeat (5) @(negedge clk);
         check("rst_mid:start_ignored", {61'd0, busy, rw_write, rw_read}, 64'(0));
         init_done = 1'b1;
         repeat (2) @(negedge clk);
      end
      run_test("after_reset", 25'd0, 25'd3, 2'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
